// File: rtl/ic_instr_mem_responder.sv
// Instruction-fetch bus responder: grants word fetches, answers in order after a fixed
// latency with address-derived data, optional error window, random grant stalls.
module ic_instr_mem_responder #(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned RespLatency    = 1,
    parameter logic [31:0] DataXor        = 32'hA5A5_5A5A,
    parameter logic [31:0] ErrBase        = 32'h0000_8000,
    parameter logic [31:0] ErrSize        = 32'h0,
    parameter logic [15:0] LfsrSeed       = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        stall_en_i,
    output logic [3:0]  outstanding_o,
    output logic        protocol_err_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(MaxOutstanding - 1);
    localparam logic [3:0] Depth   = 4'(MaxOutstanding);
    localparam logic [3:0] CntInit = 4'(RespLatency - 1);
    localparam logic [32:0] WinEnd = {1'b0, ErrBase} + {1'b0, ErrSize};

    logic [MaxOutstanding-1:0] ent_valid;
    logic [MaxOutstanding-1:0] ent_err;
    logic [31:0]               ent_data [MaxOutstanding];
    logic [3:0]                ent_cnt  [MaxOutstanding];

    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [3:0]      count;
    logic [15:0]     lfsr;
    logic            prev_pend;
    logic [31:0]     prev_addr;
    logic            proto_err;

    logic stall;
    logic full;
    logic push;
    logic pop;
    logic in_window;
    logic violation;
    logic lfsr_fb;

    // Handshake: a request transfers in a cycle where req and gnt are both high; while
    // req is high without gnt the initiator must hold req and addr stable. A response
    // transfers whenever rvalid is high; the initiator has no way to refuse it.
    assign pop            = ent_valid[rd_ptr] & (ent_cnt[rd_ptr] == 4'd0);
    assign instr_rvalid_o = pop;
    assign instr_rdata_o  = ent_data[rd_ptr];
    assign instr_err_o    = ent_err[rd_ptr];

    assign stall       = stall_en_i & lfsr[0] & lfsr[1];
    assign full        = (count == Depth);
    assign push        = instr_req_i & ~stall & ~(full & ~pop);
    assign instr_gnt_o = push;

    // 33-bit compare so a window touching the top of the address space does not wrap.
    assign in_window = (ErrSize != 32'h0) && (instr_addr_i >= ErrBase) &&
                       ({1'b0, instr_addr_i} < WinEnd);

    assign violation = (instr_req_i & (instr_addr_i[1:0] != 2'b00)) |
                       (prev_pend & (~instr_req_i | (instr_addr_i != prev_addr)));

    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    assign outstanding_o  = count;
    assign protocol_err_o = proto_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                ent_data[i] <= 32'h0;
                ent_cnt[i]  <= 4'd0;
            end
            ent_valid <= '0;
            ent_err   <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= 4'd0;
            lfsr      <= LfsrSeed;
            prev_pend <= 1'b0;
            prev_addr <= 32'h0;
            proto_err <= 1'b0;
        end else begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                if (ent_valid[i] && ent_cnt[i] != 4'd0) begin
                    ent_cnt[i] <= ent_cnt[i] - 4'd1;
                end
            end
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr <= (rd_ptr == LastIdx) ? '0 : rd_ptr + 1'b1;
            end
            // Placed after the pop so a push into the slot freed this cycle wins.
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                ent_err[wr_ptr]   <= in_window;
                ent_data[wr_ptr]  <= in_window ? 32'h0 : (instr_addr_i ^ DataXor);
                ent_cnt[wr_ptr]   <= CntInit;
                wr_ptr <= (wr_ptr == LastIdx) ? '0 : wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 4'd1;
            end else if (pop && !push) begin
                count <= count - 4'd1;
            end
            lfsr      <= {lfsr_fb, lfsr[15:1]};
            prev_pend <= instr_req_i & ~push;
            prev_addr <= instr_addr_i;
            if (violation) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ic_instr_mem_responder.sv
// Bench for ic_instr_mem_responder: directed and random fetches checked every cycle
// against a transaction-level model (response queue with due cycles).
module tb_ic_instr_mem_responder;

    localparam int          MAX   = 3;
    localparam int          LAT   = 4;
    localparam logic [31:0] XORV  = 32'hA5A5_5A5A;
    localparam logic [31:0] EBASE = 32'h0000_8000;
    localparam logic [31:0] ESIZE = 32'h0000_0010;
    localparam logic [15:0] SEED  = 16'hACE1;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        req = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        stall_en = 1'b0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  outstanding;
    logic        proto_err;

    ic_instr_mem_responder #(
        .MaxOutstanding(MAX),
        .RespLatency   (LAT),
        .DataXor       (XORV),
        .ErrBase       (EBASE),
        .ErrSize       (ESIZE),
        .LfsrSeed      (SEED)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_req_i   (req),
        .instr_addr_i  (addr),
        .instr_gnt_o   (gnt),
        .instr_rvalid_o(rvalid),
        .instr_rdata_o (rdata),
        .instr_err_o   (err),
        .stall_en_i    (stall_en),
        .outstanding_o (outstanding),
        .protocol_err_o(proto_err)
    );

    // scoreboard
    logic [31:0] exp_q[$];
    logic        err_q[$];
    int          due_q[$];
    int          cyc;
    logic [15:0] m_lfsr;
    logic        m_prev_pend;
    logic [31:0] m_prev_addr;
    logic        m_proto;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_stall = 0;
    int n_req   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic in_win(input logic [31:0] a);
        longint ua;
        ua = longint'(a);
        return (ESIZE != 0) && (ua >= longint'(EBASE)) && (ua < longint'(EBASE) + longint'(ESIZE));
    endfunction

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 32'h7FF0 + 32'($urandom_range(0, 11)) * 32'd4;
        return {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        err_q.delete();
        due_q.delete();
        m_lfsr      = SEED;
        m_prev_pend = 1'b0;
        m_prev_addr = 32'h0;
        m_proto     = 1'b0;
    endtask

    // One bus cycle: drive at the negedge, check before the posedge, advance the model.
    task automatic step(input logic r, input logic [31:0] a, input logic en, output logic e_gnt);
        logic e_rvalid;
        logic e_stall;
        logic e_err;
        int   e_out;
        req      = r;
        addr     = a;
        stall_en = en;
        e_out    = due_q.size();
        e_rvalid = 1'b0;
        if (e_out > 0) e_rvalid = (due_q[0] <= cyc);
        e_stall = en & m_lfsr[0] & m_lfsr[1];
        e_gnt   = r & ~e_stall & ~((e_out == MAX) & ~e_rvalid);
        #4;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("rvalid", 32'(rvalid), 32'(e_rvalid));
        chk("outstanding", 32'(outstanding), 32'(e_out));
        chk("protocol_err", 32'(proto_err), 32'(m_proto));
        if (e_rvalid) begin
            chk("rdata", rdata, exp_q[0]);
            chk("err", 32'(err), 32'(err_q[0]));
        end
        if (r) n_req++;
        if (r && e_stall) n_stall++;
        @(posedge clk);
        if (e_rvalid) begin
            void'(exp_q.pop_front());
            void'(err_q.pop_front());
            void'(due_q.pop_front());
        end
        if (e_gnt) begin
            e_err = in_win(a);
            err_q.push_back(e_err);
            exp_q.push_back(e_err ? 32'h0 : (a ^ XORV));
            due_q.push_back(cyc + LAT);
        end
        if ((r && a[1:0] != 2'b00) || (m_prev_pend && (!r || a != m_prev_addr))) m_proto = 1'b1;
        m_prev_pend = r & ~e_gnt;
        m_prev_addr = a;
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        cyc++;
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] a, input logic en);
        logic g;
        int   k;
        g = 1'b0;
        k = 0;
        while (!g && k < 100) begin
            step(1'b1, a, en, g);
            k++;
        end
        chk("fetch_granted", 32'(g), 32'd1);
    endtask

    task automatic idle(input int n);
        logic g;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, g);
    endtask

    // Async reset asserted mid-cycle; outputs checked before any clock edge.
    task automatic apply_reset();
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_protocol_err", 32'(proto_err), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        g;
        int          granted;
        int          guard;
        logic [31:0] cur;
        logic [31:0] ew[4];
        cyc = 0;
        apply_reset();

        // single fetch
        fetch(32'h100, 1'b0);
        idle(LAT + 2);

        // fill past the response depth with continuous requests
        fetch(32'h0, 1'b0);
        fetch(32'h4, 1'b0);
        fetch(32'h8, 1'b0);
        fetch(32'hC, 1'b0);
        idle(LAT + 4);

        // error window edges
        ew = '{32'h7FFC, 32'h8000, 32'h800C, 32'h8010};
        for (int i = 0; i < 4; i++) fetch(ew[i], 1'b0);
        idle(LAT + 4);

        // random stalls with back-to-back requests
        n_stall = 0;
        n_req   = 0;
        granted = 0;
        guard   = 0;
        cur     = rnd_addr();
        while (granted < 1000 && guard < 20000) begin
            step(1'b1, cur, 1'b1, g);
            guard++;
            if (g) begin
                granted++;
                cur = rnd_addr();
            end
        end
        chk("random_granted", 32'(granted), 32'd1000);
        chk("stall_ratio", 32'((n_stall * 100 >= n_req * 15) && (n_stall * 100 <= n_req * 35)), 32'd1);
        idle(LAT + 4);
        chk("random_protocol_clean", 32'(proto_err), 32'd0);

        // address changed while a request is stalled
        g = 1'b1;
        guard = 0;
        while (g && guard < 200) begin
            step(1'b1, 32'h20, 1'b1, g);
            guard++;
        end
        chk("stall_seen", 32'(g), 32'd0);
        step(1'b1, 32'h24, 1'b1, g);
        idle(1);
        chk("proto_addr_change", 32'(proto_err), 32'd1);
        idle(LAT + 4);
        chk("proto_sticky", 32'(proto_err), 32'd1);
        apply_reset();

        // misaligned request
        fetch(32'h22, 1'b0);
        idle(1);
        chk("proto_misaligned", 32'(proto_err), 32'd1);
        idle(LAT + 4);

        // reset with the response queue full
        fetch(32'h40, 1'b0);
        fetch(32'h44, 1'b0);
        fetch(32'h48, 1'b0);
        #1 chk("pre_reset_outstanding", 32'(outstanding), 32'd3);
        apply_reset();
        idle(LAT + 4);
        fetch(32'h8004, 1'b0);
        idle(LAT + 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
